// File: rtl/ddr_bram_responder.sv
// ---------------------------------------------------------------------------
// ddr_bram_responder
//
// Block-RAM-backed stand-in for the DDR3 user command interface. It accepts
// one read or write burst command at a time, stores write beats into an
// internal word array and plays read beats back after a fixed latency with
// rd_data_end_o framing on the last beat. Used for simulation and FPGA
// bring-up in place of the real DDR3 controller IP.
//
// Parameters
//   ADDR_W      word-address bits used; the array holds 2**ADDR_W words
//   BURST_LEN   beats per command (1..16)
//   RD_LATENCY  cycles from command accept edge to first read beat (>= 2)
//
// Ports
//   clk              rising-edge clock for all logic
//   rst              synchronous reset, active high
//   cmd_en_i         command valid
//   cmd_i            command type: 0 = read, 1 = write
//   addr_i           word address, only bits [ADDR_W-1:0] are used
//   cmd_rdy_o        high while a new command can be accepted
//   wr_data_en_i     write beat valid
//   wr_data_i        write beat data
//   wr_data_end_i    initiator marks the last write beat of the burst
//   wr_data_rdy_o    high while write beats are being accepted
//   rd_data_o        read beat data, forced to 0 when no beat is valid
//   rd_data_valid_o  read beat valid
//   rd_data_end_o    marks the last read beat of the burst
//   proto_err_o      sticky protocol-violation flag, cleared only by rst
// ---------------------------------------------------------------------------
module ddr_bram_responder #(
    parameter int ADDR_W     = 10,
    parameter int BURST_LEN  = 4,
    parameter int RD_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_en_i,
    input  logic        cmd_i,
    input  logic [28:0] addr_i,
    output logic        cmd_rdy_o,
    input  logic        wr_data_en_i,
    input  logic [31:0] wr_data_i,
    input  logic        wr_data_end_i,
    output logic        wr_data_rdy_o,
    output logic [31:0] rd_data_o,
    output logic        rd_data_valid_o,
    output logic        rd_data_end_o,
    output logic        proto_err_o
);

    localparam int DEPTH  = 2 ** ADDR_W;
    // Beat counter must be able to hold BURST_LEN itself: in READ it runs one
    // past the last beat index after the final beat has been fetched.
    localparam int BEAT_W = $clog2(BURST_LEN + 1);
    localparam int CNT_W  = $clog2(RD_LATENCY + 1);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0]  LAST_WAIT = CNT_W'(RD_LATENCY - 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WRITE     = 2'd1;
    localparam logic [1:0] S_READ_WAIT = 2'd2;
    localparam logic [1:0] S_READ      = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] base_addr;
    logic [BEAT_W-1:0] beat;
    logic [CNT_W-1:0]  wait_cnt;
    logic [ADDR_W-1:0] beat_addr;
    logic              wr_fire;
    logic              wr_last;

    logic [31:0] mem [DEPTH];

    // Address bits above ADDR_W are deliberately ignored.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_i[28:ADDR_W];

    // Handshake outputs follow the state directly, so cmd_rdy_o drops the
    // cycle after an accept and rises the cycle after the burst finishes.
    assign cmd_rdy_o     = (state == S_IDLE);
    assign wr_data_rdy_o = (state == S_WRITE);

    // The adder truncates to ADDR_W bits, which gives the modulo-DEPTH wrap
    // within a burst for free. The beat counter is cleared on accept, so the
    // same address serves the first read fetch out of READ_WAIT.
    assign beat_addr = base_addr + ADDR_W'(beat);
    assign wr_last   = (beat == LAST_BEAT);
    assign wr_fire   = (state == S_WRITE) && wr_data_en_i;

    // -----------------------------------------------------------------------
    // Storage array
    // -----------------------------------------------------------------------
    // NOTE: the array has no reset branch; clearing a RAM needs one write per
    // word and would stop the synthesiser from mapping it onto block RAM.
    // The !rst term keeps a beat arriving on the reset edge out of memory,
    // because reset aborts the burst it belongs to.
    always_ff @(posedge clk) begin
        if (!rst && wr_fire) begin
            mem[beat_addr] <= wr_data_i;
        end
    end

    // -----------------------------------------------------------------------
    // Control FSM and registered read outputs
    // -----------------------------------------------------------------------
    // NOTE: every state register here uses non-blocking assignment so each
    // branch reads the pre-edge values of state, beat and rd_data_end_o;
    // blocking assignment would let later statements see updated values and
    // make the behaviour depend on statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            base_addr       <= '0;
            beat            <= '0;
            wait_cnt        <= '0;
            rd_data_o       <= '0;
            rd_data_valid_o <= 1'b0;
            rd_data_end_o   <= 1'b0;
            proto_err_o     <= 1'b0;
        end else begin
            // A write beat offered while no write burst is open is dropped
            // and flagged.
            if (wr_data_en_i && (state != S_WRITE)) begin
                proto_err_o <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (cmd_en_i) begin
                        base_addr <= addr_i[ADDR_W-1:0];
                        beat      <= '0;
                        wait_cnt  <= '0;
                        state     <= cmd_i ? S_WRITE : S_READ_WAIT;
                    end
                end

                S_WRITE: begin
                    // Gaps are allowed: nothing advances without a beat.
                    if (wr_data_en_i) begin
                        beat <= beat + 1'b1;
                        // The burst closes on whichever comes first: the
                        // initiator's end marker or the final beat count.
                        // They must coincide, otherwise the initiator and
                        // responder disagree on the burst length.
                        if (wr_last || wr_data_end_i) begin
                            state <= S_IDLE;
                            if (wr_last != wr_data_end_i) begin
                                proto_err_o <= 1'b1;
                            end
                        end
                    end
                end

                S_READ_WAIT: begin
                    // wait_cnt is 0 on the first edge after accept, so the
                    // fetch below lands on accept edge + RD_LATENCY.
                    if (wait_cnt == LAST_WAIT) begin
                        state           <= S_READ;
                        rd_data_o       <= mem[beat_addr];
                        rd_data_valid_o <= 1'b1;
                        rd_data_end_o   <= (beat == LAST_BEAT);
                        beat            <= beat + 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                S_READ: begin
                    // The registered end flag means the last beat is already
                    // on the outputs; retire the burst on this edge.
                    if (rd_data_end_o) begin
                        state           <= S_IDLE;
                        rd_data_o       <= '0;
                        rd_data_valid_o <= 1'b0;
                        rd_data_end_o   <= 1'b0;
                    end else begin
                        rd_data_o     <= mem[beat_addr];
                        rd_data_end_o <= (beat == LAST_BEAT);
                        beat          <= beat + 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_bram_responder.sv
// ---------------------------------------------------------------------------
// tb_ddr_bram_responder
//
// Directed bench for ddr_bram_responder with default parameters
// (ADDR_W=10, BURST_LEN=4, RD_LATENCY=4). Each scenario task drives its own
// stimulus and compares outputs against hand-computed expected values.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_ddr_bram_responder;

    localparam int ADDR_W     = 10;
    localparam int BURST_LEN  = 4;
    localparam int RD_LATENCY = 4;
    localparam int CAP_LAST   = RD_LATENCY + BURST_LEN;

    logic        clk;
    logic        rst;
    logic        cmd_en;
    logic        cmd;
    logic [28:0] addr;
    logic        cmd_rdy;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        wr_end;
    logic        wr_rdy;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_end;
    logic        proto_err;

    int n_pass  = 0;
    int n_total = 0;

    // Read capture: index k is the sample taken k cycles after the accept edge.
    logic        cap_valid [16];
    logic [31:0] cap_data  [16];
    logic        cap_end   [16];
    logic        cap_rdy   [16];

    // Write burst observations.
    logic wr_rdy_start;
    logic rdy_seen;
    logic rdy_after;

    ddr_bram_responder #(
        .ADDR_W    (ADDR_W),
        .BURST_LEN (BURST_LEN),
        .RD_LATENCY(RD_LATENCY)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_en_i       (cmd_en),
        .cmd_i          (cmd),
        .addr_i         (addr),
        .cmd_rdy_o      (cmd_rdy),
        .wr_data_en_i   (wr_en),
        .wr_data_i      (wr_data),
        .wr_data_end_i  (wr_end),
        .wr_data_rdy_o  (wr_rdy),
        .rd_data_o      (rd_data),
        .rd_data_valid_o(rd_valid),
        .rd_data_end_o  (rd_end),
        .proto_err_o    (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command and hold it until the edge on which it is accepted.
    // Returns one time unit after the accept edge.
    task automatic issue(input logic wr, input logic [28:0] a);
        int guard;
        guard  = 0;
        cmd_en = 1'b1;
        cmd    = wr;
        addr   = a;
        while (cmd_rdy !== 1'b1 && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) begin
            n_total++;
            $display("FAIL issue_timeout: cmd_rdy_o stayed %b, required 1", cmd_rdy);
        end
        tick();
        cmd_en = 1'b0;
    endtask

    // Drive a write burst: beats d[i*32+:32], wr_data_end_i on beat end_at,
    // optional idle cycle between beats.
    task automatic write_burst(input logic [28:0] a, input logic [127:0] d,
                               input int n_beats, input int end_at, input bit gap);
        issue(1'b1, a);
        wr_rdy_start = wr_rdy;
        rdy_seen     = 1'b0;
        rdy_after    = 1'b0;
        for (int i = 0; i < n_beats; i++) begin
            if (gap && i > 0) begin
                wr_en  = 1'b0;
                wr_end = 1'b0;
                tick();
                rdy_seen = rdy_seen | cmd_rdy;
            end
            wr_en   = 1'b1;
            wr_data = d[i*32 +: 32];
            wr_end  = (i == end_at);
            tick();
            if (i < n_beats - 1) rdy_seen = rdy_seen | cmd_rdy;
            else                 rdy_after = cmd_rdy;
        end
        wr_en  = 1'b0;
        wr_end = 1'b0;
    endtask

    // Record outputs for CAP_LAST cycles after an accept edge.
    task automatic capture_read();
        for (int k = 1; k <= CAP_LAST; k++) begin
            tick();
            cap_valid[k] = rd_valid;
            cap_data[k]  = rd_data;
            cap_end[k]   = rd_end;
            cap_rdy[k]   = cmd_rdy;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_total++;
        if ({cmd_rdy, wr_rdy, rd_valid, rd_end, proto_err} !== 5'b10000 || rd_data !== 32'h0) begin
            $display("FAIL reset_state: got rdy=%b wrdy=%b valid=%b end=%b err=%b data=%h, required 1 0 0 0 0 0",
                     cmd_rdy, wr_rdy, rd_valid, rd_end, proto_err, rd_data);
        end else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        logic [127:0] exp;
        logic early;
        exp = {32'h44, 32'h33, 32'h22, 32'h11};
        write_burst(29'h010, exp, 4, 3, 1'b0);
        n_total++;
        if (wr_rdy_start !== 1'b1) $display("FAIL t1_wr_rdy: got %b, required 1", wr_rdy_start);
        else n_pass++;
        n_total++;
        if (rdy_seen !== 1'b0 || rdy_after !== 1'b1)
            $display("FAIL t1_cmd_rdy: got during=%b after=%b, required 0 1", rdy_seen, rdy_after);
        else n_pass++;
        n_total++;
        if (proto_err !== 1'b0) $display("FAIL t1_no_err: got %b, required 0", proto_err);
        else n_pass++;

        issue(1'b0, 29'h010);
        capture_read();
        early = 1'b0;
        for (int k = 1; k < RD_LATENCY; k++) early = early | cap_valid[k];
        n_total++;
        if (early !== 1'b0) $display("FAIL t1_latency: valid before cycle %0d, required none", RD_LATENCY);
        else n_pass++;
        for (int b = 0; b < BURST_LEN; b++) begin
            n_total++;
            if (cap_valid[RD_LATENCY+b] !== 1'b1 || cap_data[RD_LATENCY+b] !== exp[b*32 +: 32] ||
                cap_end[RD_LATENCY+b] !== (b == BURST_LEN - 1))
                $display("FAIL t1_beat%0d: got v=%b d=%h e=%b, required v=1 d=%h e=%b", b,
                         cap_valid[RD_LATENCY+b], cap_data[RD_LATENCY+b], cap_end[RD_LATENCY+b],
                         exp[b*32 +: 32], (b == BURST_LEN - 1));
            else n_pass++;
        end
        n_total++;
        if (cap_valid[CAP_LAST] !== 1'b0 || cap_end[CAP_LAST] !== 1'b0 ||
            cap_data[CAP_LAST] !== 32'h0 || cap_rdy[CAP_LAST] !== 1'b1)
            $display("FAIL t1_after: got v=%b e=%b d=%h rdy=%b, required 0 0 0 1",
                     cap_valid[CAP_LAST], cap_end[CAP_LAST], cap_data[CAP_LAST], cap_rdy[CAP_LAST]);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [127:0] exp;
        write_burst(29'h000, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 4, 3, 1'b0);
        write_burst(29'h3FE, {32'h4, 32'h3, 32'h2, 32'h1}, 4, 3, 1'b0);
        n_total++;
        if (proto_err !== 1'b0) $display("FAIL t2_no_err: got %b, required 0", proto_err);
        else n_pass++;

        issue(1'b0, 29'h000);
        capture_read();
        exp = {32'hA3, 32'hA2, 32'h4, 32'h3};
        for (int b = 0; b < BURST_LEN; b++) begin
            n_total++;
            if (cap_valid[RD_LATENCY+b] !== 1'b1 || cap_data[RD_LATENCY+b] !== exp[b*32 +: 32] ||
                cap_end[RD_LATENCY+b] !== (b == BURST_LEN - 1))
                $display("FAIL t2_rd0_beat%0d: got v=%b d=%h e=%b, required v=1 d=%h", b,
                         cap_valid[RD_LATENCY+b], cap_data[RD_LATENCY+b], cap_end[RD_LATENCY+b],
                         exp[b*32 +: 32]);
            else n_pass++;
        end

        // Bit 28 set: upper address bits must be ignored.
        issue(1'b0, 29'h1000_03FE);
        capture_read();
        exp = {32'h4, 32'h3, 32'h2, 32'h1};
        for (int b = 0; b < BURST_LEN; b++) begin
            n_total++;
            if (cap_valid[RD_LATENCY+b] !== 1'b1 || cap_data[RD_LATENCY+b] !== exp[b*32 +: 32] ||
                cap_end[RD_LATENCY+b] !== (b == BURST_LEN - 1))
                $display("FAIL t2_rd3fe_beat%0d: got v=%b d=%h e=%b, required v=1 d=%h", b,
                         cap_valid[RD_LATENCY+b], cap_data[RD_LATENCY+b], cap_end[RD_LATENCY+b],
                         exp[b*32 +: 32]);
            else n_pass++;
        end
    endtask

    task automatic test_gapped_write();
        logic [127:0] exp;
        exp = {32'h44, 32'h33, 32'h22, 32'h11};
        write_burst(29'h020, exp, 4, 3, 1'b1);
        n_total++;
        if (rdy_seen !== 1'b0 || rdy_after !== 1'b1 || proto_err !== 1'b0)
            $display("FAIL t3_gap_handshake: got during=%b after=%b err=%b, required 0 1 0",
                     rdy_seen, rdy_after, proto_err);
        else n_pass++;
        issue(1'b0, 29'h020);
        capture_read();
        for (int b = 0; b < BURST_LEN; b++) begin
            n_total++;
            if (cap_valid[RD_LATENCY+b] !== 1'b1 || cap_data[RD_LATENCY+b] !== exp[b*32 +: 32] ||
                cap_end[RD_LATENCY+b] !== (b == BURST_LEN - 1))
                $display("FAIL t3_beat%0d: got v=%b d=%h e=%b, required v=1 d=%h", b,
                         cap_valid[RD_LATENCY+b], cap_data[RD_LATENCY+b], cap_end[RD_LATENCY+b],
                         exp[b*32 +: 32]);
            else n_pass++;
        end
    endtask

    task automatic test_write_errors();
        // Early end marker on beat 1.
        write_burst(29'h040, {32'h0, 32'h0, 32'h66, 32'h55}, 2, 1, 1'b0);
        n_total++;
        if (rdy_after !== 1'b1 || proto_err !== 1'b1)
            $display("FAIL t4_early_end: got rdy=%b err=%b, required 1 1", rdy_after, proto_err);
        else n_pass++;
        issue(1'b0, 29'h040);
        capture_read();
        n_total++;
        if (cap_data[RD_LATENCY] !== 32'h55 || cap_data[RD_LATENCY+1] !== 32'h66)
            $display("FAIL t4_short_data: got %h %h, required 00000055 00000066",
                     cap_data[RD_LATENCY], cap_data[RD_LATENCY+1]);
        else n_pass++;

        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++;
        if (proto_err !== 1'b0) $display("FAIL t4_err_clear: got %b, required 0", proto_err);
        else n_pass++;

        // Stray write beat while idle.
        wr_en   = 1'b1;
        wr_data = 32'hDEAD;
        tick();
        wr_en = 1'b0;
        n_total++;
        if (proto_err !== 1'b1 || cmd_rdy !== 1'b1)
            $display("FAIL t4_idle_wr_en: got err=%b rdy=%b, required 1 1", proto_err, cmd_rdy);
        else n_pass++;
        tick();
        n_total++;
        if (proto_err !== 1'b1) $display("FAIL t4_sticky: got %b, required 1", proto_err);
        else n_pass++;

        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Missing end marker on the final beat.
        write_burst(29'h050, {32'h9, 32'h8, 32'h7, 32'h6}, 4, 99, 1'b0);
        n_total++;
        if (rdy_after !== 1'b1 || proto_err !== 1'b1)
            $display("FAIL t4_missing_end: got rdy=%b err=%b, required 1 1", rdy_after, proto_err);
        else n_pass++;

        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [127:0] exp;
        logic busy_rdy;
        issue(1'b0, 29'h010);
        // Second command held from the start of the first burst.
        cmd_en = 1'b1;
        cmd    = 1'b0;
        addr   = 29'h3FE;
        capture_read();
        busy_rdy = 1'b0;
        for (int k = 1; k < CAP_LAST; k++) busy_rdy = busy_rdy | cap_rdy[k];
        n_total++;
        if (busy_rdy !== 1'b0 || cap_rdy[CAP_LAST] !== 1'b1)
            $display("FAIL t5_rdy_window: got busy=%b final=%b, required 0 1", busy_rdy, cap_rdy[CAP_LAST]);
        else n_pass++;
        exp = {32'h44, 32'h33, 32'h22, 32'h11};
        for (int b = 0; b < BURST_LEN; b++) begin
            n_total++;
            if (cap_valid[RD_LATENCY+b] !== 1'b1 || cap_data[RD_LATENCY+b] !== exp[b*32 +: 32] ||
                cap_end[RD_LATENCY+b] !== (b == BURST_LEN - 1))
                $display("FAIL t5_first_beat%0d: got v=%b d=%h e=%b, required v=1 d=%h", b,
                         cap_valid[RD_LATENCY+b], cap_data[RD_LATENCY+b], cap_end[RD_LATENCY+b],
                         exp[b*32 +: 32]);
            else n_pass++;
        end

        // Held command is taken on the first ready edge.
        tick();
        cmd_en = 1'b0;
        n_total++;
        if (cmd_rdy !== 1'b0) $display("FAIL t5_accept: got cmd_rdy=%b, required 0", cmd_rdy);
        else n_pass++;
        capture_read();
        exp = {32'h4, 32'h3, 32'h2, 32'h1};
        n_total++;
        if (cap_valid[RD_LATENCY-1] !== 1'b0)
            $display("FAIL t5_second_latency: got early valid=%b, required 0", cap_valid[RD_LATENCY-1]);
        else n_pass++;
        for (int b = 0; b < BURST_LEN; b++) begin
            n_total++;
            if (cap_valid[RD_LATENCY+b] !== 1'b1 || cap_data[RD_LATENCY+b] !== exp[b*32 +: 32] ||
                cap_end[RD_LATENCY+b] !== (b == BURST_LEN - 1))
                $display("FAIL t5_second_beat%0d: got v=%b d=%h e=%b, required v=1 d=%h", b,
                         cap_valid[RD_LATENCY+b], cap_data[RD_LATENCY+b], cap_end[RD_LATENCY+b],
                         exp[b*32 +: 32]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_read();
        logic [127:0] exp;
        logic late;
        exp = {32'h44, 32'h33, 32'h22, 32'h11};
        // Make the flag set so the reset clearing it is observable.
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        issue(1'b0, 29'h010);
        for (int k = 1; k <= RD_LATENCY + 1; k++) tick();
        n_total++;
        if (rd_valid !== 1'b1 || rd_data !== 32'h22 || proto_err !== 1'b1)
            $display("FAIL t6_pre_reset: got v=%b d=%h err=%b, required 1 00000022 1",
                     rd_valid, rd_data, proto_err);
        else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++;
        if (rd_valid !== 1'b0 || rd_end !== 1'b0 || rd_data !== 32'h0 || cmd_rdy !== 1'b1 || proto_err !== 1'b0)
            $display("FAIL t6_post_reset: got v=%b e=%b d=%h rdy=%b err=%b, required 0 0 0 1 0",
                     rd_valid, rd_end, rd_data, cmd_rdy, proto_err);
        else n_pass++;
        late = 1'b0;
        for (int k = 0; k < BURST_LEN + 1; k++) begin
            tick();
            late = late | rd_valid;
        end
        n_total++;
        if (late !== 1'b0) $display("FAIL t6_no_more_beats: got valid=%b, required 0", late);
        else n_pass++;

        issue(1'b0, 29'h010);
        capture_read();
        for (int b = 0; b < BURST_LEN; b++) begin
            n_total++;
            if (cap_valid[RD_LATENCY+b] !== 1'b1 || cap_data[RD_LATENCY+b] !== exp[b*32 +: 32] ||
                cap_end[RD_LATENCY+b] !== (b == BURST_LEN - 1))
                $display("FAIL t6_reread_beat%0d: got v=%b d=%h e=%b, required v=1 d=%h", b,
                         cap_valid[RD_LATENCY+b], cap_data[RD_LATENCY+b], cap_end[RD_LATENCY+b],
                         exp[b*32 +: 32]);
            else n_pass++;
        end
    endtask

    initial begin
        rst     = 1'b1;
        cmd_en  = 1'b0;
        cmd     = 1'b0;
        addr    = '0;
        wr_en   = 1'b0;
        wr_data = '0;
        wr_end  = 1'b0;
        test_reset();
        test_write_read();
        test_wrap();
        test_gapped_write();
        test_write_errors();
        test_back_to_back();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
